// File: rtl/gf128_mult_serial.sv
// rtl/gf128_mult_serial.sv - digit-serial GF(2^128) multiplier with GHASH chaining
//
// Computes z = m * y in GF(2^128) using the GCM field polynomial and GCM bit
// ordering. Port bit 127 holds the coefficient of alpha^0. Each BUSY cycle
// consumes DIGIT_W bits of y. The multiplicand m is x, or x ^ acc when chain=1.
// acc is loaded with the last result on every output handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set valid
//   in_ready   block idle and able to accept operands
//   x          multiplicand
//   y          multiplier (hash key H for GHASH)
//   chain      use x ^ acc as the multiplicand (qualified by in_valid)
//   out_valid  result valid
//   out_ready  consumer accepts result
//   z          product, held from the last completed operation
module gf128_mult_serial #(
    parameter int DIGIT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] x,
    input  logic [127:0] y,
    input  logic         chain,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] z
);

    localparam int ITER  = 128 / DIGIT_W;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [127:0] R_POLY = {8'hE1, 120'h0};

    generate
        if (!(DIGIT_W == 1  || DIGIT_W == 2  || DIGIT_W == 4  || DIGIT_W == 8 ||
              DIGIT_W == 16 || DIGIT_W == 32 || DIGIT_W == 64 || DIGIT_W == 128)) begin : g_bad_digit
            $fatal(1, "gf128_mult_serial: DIGIT_W must be a power of two from 1 to 128");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Held low through reset and set on the first edge after release, so
    // in_ready stays low while rst_n is asserted even though state is IDLE.
    logic started;

    logic [127:0] acc;
    logic [127:0] v;
    logic [127:0] ysh;
    logic [127:0] zacc;
    logic [127:0] z_r;
    logic [CNT_W-1:0] cnt;

    logic [127:0] v_step;
    logic [127:0] ysh_step;
    logic [127:0] zacc_step;
    logic         last;

    // Multiplication by alpha: shift toward higher powers, fold alpha^128 back.
    function automatic logic [127:0] reduce(input logic [127:0] a);
        reduce = (a >> 1) ^ (a[0] ? R_POLY : 128'h0);
    endfunction

    // One BUSY cycle: DIGIT_W unrolled shift-and-add steps. ysh is walked one
    // bit at a time so the top bit is always the next multiplier bit.
    always_comb begin
        v_step    = v;
        ysh_step  = ysh;
        zacc_step = zacc;
        for (int k = 0; k < DIGIT_W; k++) begin
            if (ysh_step[127]) begin
                zacc_step = zacc_step ^ v_step;
            end
            v_step   = reduce(v_step);
            ysh_step = {ysh_step[126:0], 1'b0};
        end
    end

    assign last = (cnt == CNT_W'(ITER - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = started && (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE: if (in_valid && in_ready) state_nxt = BUSY;
            BUSY: if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= 128'h0;
            v    <= 128'h0;
            ysh  <= 128'h0;
            zacc <= 128'h0;
            z_r  <= 128'h0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        v    <= chain ? (x ^ acc) : x;
                        ysh  <= y;
                        zacc <= 128'h0;
                        cnt  <= '0;
                    end
                end
                BUSY: begin
                    v    <= v_step;
                    ysh  <= ysh_step;
                    zacc <= zacc_step;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        z_r <= zacc_step;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc <= z_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign z = z_r;

endmodule

// File: tb/tb_gf128_mult_serial.sv
// tb/tb_gf128_mult_serial.sv - directed testbench for gf128_mult_serial
module tb_gf128_mult_serial;

    localparam logic [127:0] H_KEY  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C_BLK  = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] X1_EXP = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] LEN_BK = 128'h00000000000000000000000000000080;
    localparam logic [127:0] X2_EXP = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
    localparam logic [127:0] ONE    = {1'b1, 127'h0};
    localparam logic [127:0] ALPHA1 = {2'b01, 126'h0};
    localparam logic [127:0] RED_EXP = {8'hE1, 120'h0};
    localparam logic [127:0] ID_X   = 128'h0123456789abcdeffedcba9876543210;

    logic         clk;
    logic         rst_n;
    logic [127:0] x_s;
    logic [127:0] y_s;
    logic         chain_s;
    logic         in_valid  [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [127:0] z         [3];

    int n_vec;
    int n_err;

    // Instance 0: DIGIT_W=8, instance 1: DIGIT_W=1, instance 2: DIGIT_W=128.
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            gf128_mult_serial #(
                .DIGIT_W((g == 0) ? 8 : ((g == 1) ? 1 : 128))
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .x         (x_s),
                .y         (y_s),
                .chain     (chain_s),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .z         (z[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int iter_of(input int d);
        iter_of = (d == 0) ? 16 : ((d == 1) ? 128 : 1);
    endfunction

    // Bit-serial GCM multiply as written in the GCM definition.
    function automatic logic [127:0] gmul_ref(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] zz;
        logic [127:0] vv;
        zz = 128'h0;
        vv = a;
        for (int i = 0; i < 128; i++) begin
            if (b[127 - i]) zz = zz ^ vv;
            vv = vv[0] ? ((vv >> 1) ^ RED_EXP) : (vv >> 1);
        end
        gmul_ref = zz;
    endfunction

    // Present operands, wait for the accept edge, then count cycles to out_valid.
    task automatic run_op(input int d, input logic [127:0] xv, input logic [127:0] yv,
                          input logic ch, output logic [127:0] res, output int lat);
        x_s = xv;
        y_s = yv;
        chain_s = ch;
        in_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (out_valid[d]) begin
                lat = c;
                break;
            end
        end
        res = z[d];
    endtask

    // With out_ready high the handshake happens on the next edge.
    task automatic drain();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (in_ready[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_in_ready[%0d]: got %b expected 0", d, in_ready[d]);
            end
            n_vec++;
            if (out_valid[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_out_valid[%0d]: got %b expected 0", d, out_valid[d]);
            end
            n_vec++;
            if (z[d] !== 128'h0) begin
                n_err++;
                $display("FAIL reset_z[%0d]: got %h expected 0", d, z[d]);
            end
        end
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (in_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL release_in_ready_before_edge: got %b expected 0", in_ready[0]);
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (in_ready[d] !== 1'b1) begin
                n_err++;
                $display("FAIL release_in_ready[%0d]: got %b expected 1", d, in_ready[d]);
            end
        end
    endtask

    task automatic test_identity();
        logic [127:0] r;
        int lat;
        run_op(0, ID_X, ONE, 1'b0, r, lat);
        n_vec++;
        if (r !== ID_X) begin
            n_err++;
            $display("FAIL identity_z: got %h expected %h", r, ID_X);
        end
        n_vec++;
        if (lat !== 16) begin
            n_err++;
            $display("FAIL identity_latency: got %0d expected 16", lat);
        end
        drain();
        n_vec++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL identity_return_idle: out_valid=%b in_ready=%b expected 0/1",
                     out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_reduction();
        logic [127:0] r;
        int lat;
        run_op(0, 128'h1, ALPHA1, 1'b0, r, lat);
        n_vec++;
        if (r !== RED_EXP) begin
            n_err++;
            $display("FAIL reduction_z: got %h expected %h", r, RED_EXP);
        end
        drain();
        run_op(0, 128'h0, H_KEY, 1'b0, r, lat);
        n_vec++;
        if (r !== 128'h0) begin
            n_err++;
            $display("FAIL zero_x_z: got %h expected 0", r);
        end
        drain();
    endtask

    task automatic test_gcm_vector();
        logic [127:0] r;
        int lat;
        for (int d = 0; d < 3; d++) begin
            run_op(d, C_BLK, H_KEY, 1'b0, r, lat);
            n_vec++;
            if (r !== X1_EXP) begin
                n_err++;
                $display("FAIL gcm_vector_z[%0d]: got %h expected %h", d, r, X1_EXP);
            end
            n_vec++;
            if (lat !== iter_of(d)) begin
                n_err++;
                $display("FAIL gcm_vector_latency[%0d]: got %0d expected %0d", d, lat, iter_of(d));
            end
            drain();
        end
    endtask

    task automatic test_chaining();
        logic [127:0] r;
        logic [127:0] e;
        int lat;
        run_op(0, C_BLK, H_KEY, 1'b0, r, lat);
        drain();
        e = gmul_ref(X1_EXP, H_KEY);
        run_op(0, 128'h0, H_KEY, 1'b1, r, lat);
        n_vec++;
        if (r !== e) begin
            n_err++;
            $display("FAIL chain_x0_z: got %h expected %h", r, e);
        end
        drain();
        run_op(0, C_BLK, H_KEY, 1'b0, r, lat);
        drain();
        run_op(0, LEN_BK, H_KEY, 1'b1, r, lat);
        n_vec++;
        if (r !== X2_EXP) begin
            n_err++;
            $display("FAIL chain_ghash_z: got %h expected %h", r, X2_EXP);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [127:0] r;
        logic [127:0] e;
        logic [127:0] a;
        int lat;
        int bad_ov;
        int bad_z;
        int bad_ir;
        a = 128'hfedcba98765432100123456789abcdef;
        e = gmul_ref(a, H_KEY);
        out_ready[0] = 1'b0;
        run_op(0, a, H_KEY, 1'b0, r, lat);
        n_vec++;
        if (r !== e) begin
            n_err++;
            $display("FAIL backpressure_z: got %h expected %h", r, e);
        end
        bad_ov = 0;
        bad_z = 0;
        bad_ir = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid[0] = c[0];
            x_s = {$urandom, $urandom, $urandom, $urandom};
            y_s = {$urandom, $urandom, $urandom, $urandom};
            chain_s = $urandom_range(0, 1) == 1;
            @(posedge clk);
            #1;
            if (out_valid[0] !== 1'b1) bad_ov++;
            if (z[0] !== e) bad_z++;
            if (in_ready[0] !== 1'b0) bad_ir++;
        end
        in_valid[0] = 1'b0;
        n_vec++;
        if (bad_ov != 0) begin
            n_err++;
            $display("FAIL hold_out_valid: %0d cycles dropped, expected 0", bad_ov);
        end
        n_vec++;
        if (bad_z != 0) begin
            n_err++;
            $display("FAIL hold_z: %0d cycles changed, last %h expected %h", bad_z, z[0], e);
        end
        n_vec++;
        if (bad_ir != 0) begin
            n_err++;
            $display("FAIL hold_in_ready: %0d cycles high, expected 0", bad_ir);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_err++;
            $display("FAIL release_to_idle: out_valid=%b in_ready=%b expected 0/1",
                     out_valid[0], in_ready[0]);
        end
        // acc must hold the held result, not any operand offered while blocked.
        run_op(0, 128'h0, ONE, 1'b1, r, lat);
        n_vec++;
        if (r !== e) begin
            n_err++;
            $display("FAIL acc_after_backpressure: got %h expected %h", r, e);
        end
        drain();
    endtask

    task automatic test_reset_abort();
        logic [127:0] r;
        int lat;
        x_s = ID_X;
        y_s = H_KEY;
        chain_s = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid[0] !== 1'b0 || z[0] !== 128'h0 || in_ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_in_reset: out_valid=%b z=%h in_ready=%b expected 0/0/0",
                     out_valid[0], z[0], in_ready[0]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_release: in_ready=%b out_valid=%b expected 1/0",
                     in_ready[0], out_valid[0]);
        end
        run_op(0, C_BLK, H_KEY, 1'b1, r, lat);
        n_vec++;
        if (r !== X1_EXP) begin
            n_err++;
            $display("FAIL abort_acc_cleared: got %h expected %h", r, X1_EXP);
        end
        drain();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        x_s = 128'h0;
        y_s = 128'h0;
        chain_s = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b1;
        end
        test_reset();
        test_identity();
        test_reduction();
        test_gcm_vector();
        test_chaining();
        test_backpressure();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gf128_mult_serial.md
Name: gf128_mult_serial

Overview:
- Sequential, digit-serial GF(2^128) multiplier using the GCM field polynomial and bit ordering. Successor to the team's single-cycle combinational multiplier.
- Processes DIGIT_W bits of operand y per clock, so area and latency can be traded by parameter.
- Adds valid/ready handshakes on input and output, plus an optional GHASH chaining mode: z = (x ^ previous z) · y.
- Sits in the GCM datapath between block-formatting logic and the tag generator.

Parameters:
- DIGIT_W, default 8: bits of y consumed per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64, 128. Any other value is a fatal elaboration error.
- ITER, default 128/DIGIT_W: derived localparam (not overridable); number of compute cycles per operation.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- x  in  128  multiplicand.
- y  in  128  multiplier (the hash key H in GHASH use).
- chain  in  1  when 1, the effective multiplicand is x ^ acc. Qualified by in_valid.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- z  out  128  product.

Behaviour:
- Bit order: port bit 127 is GCM bit 0 (coefficient of alpha^0). Port bit 0 is the coefficient of alpha^127.
- Reduction: when the bit shifted out of v[0] is 1, v = (v >> 1) ^ {8'hE1, 120'h0}. Otherwise v = v >> 1.
- Reset (async, while rst_n=0):
  - state = IDLE.
  - in_ready = 0 while rst_n is low, then 1 from the first clock edge after release.
  - out_valid = 0.
  - z = 0, acc = 0, internal v/zacc/ycnt = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready:
    - latch v = chain ? (x ^ acc) : x.
    - latch ysh = y, zacc = 0, cnt = 0.
    - go to BUSY.
- BUSY:
  - in_ready = 0, out_valid = 0.
  - Each cycle, unroll DIGIT_W serial steps. Step k: if ysh[127-k], zacc ^= v; then v = reduce(v).
  - After the steps: ysh <<= DIGIT_W, cnt += 1.
  - When cnt == ITER-1 this cycle: register z = final zacc and go to DONE.
- DONE:
  - out_valid = 1; z is held stable until the handshake.
  - On out_ready: acc = z, out_valid drops next cycle, go to IDLE.
- Latency: if the input handshake occurs at edge T, out_valid is high after edge T+ITER (e.g. 16 cycles for DIGIT_W=8, 1 cycle for DIGIT_W=128).
- Throughput: one operation per ITER+2 cycles with out_ready tied high. There is no overlap of operations.
- in_ready is combinationally (state==IDLE) and has no dependence on in_valid or out_ready.
- Simultaneous events: in_valid during BUSY or DONE is ignored, and x/y/chain are not sampled. The source must hold them until in_ready.
- Backpressure: out_ready low in DONE holds z and out_valid indefinitely. acc is updated only on the output handshake.
- Chaining:
  - chain=1 with acc never written uses acc = 0, so the result equals x·y.
  - chain=0 still updates acc on output handshake, which starts a new GHASH chain.
- Reset mid-operation: asserting rst_n low in BUSY or DONE aborts immediately. No output handshake occurs and acc returns to 0.
- z is zero in reset, otherwise holds the last result, including in IDLE/BUSY. Consumers must only use z when out_valid=1.
- Functional equivalence: for all DIGIT_W, with chain=0, z equals the single-cycle combinational multiplier's output for the same x, y.

Test Plan:
- Identity: x=128'h0123456789abcdeffedcba9876543210, y=128'h8000_0000_0000_0000_0000_0000_0000_0000 (GCM "1"), chain=0 -> z=x, out_valid asserted exactly ITER cycles after the accept edge.
- Reduction: x=128'h1, y=128'h4000..0 (alpha^1) -> z=128'hE1000000_00000000_00000000_00000000. Also x=0 with any y -> z=0.
- GCM vector: y=H=66e94bd4ef8a2c3b884cfa59ca342b2e, x=0388dace60b6a392f328c2b971b2fe78, chain=0 -> z=5e2ec746917062882c85b0685353deb7. Run for DIGIT_W = 1, 8, 128.
- Chaining: repeat the previous op, then chain=1 with x=0 and the same y -> z = 5e2e..deb7 · H, matching the combinational reference model; acc updated only after out_ready.
- Backpressure/ignore: hold out_ready=0 for 20 cycles, toggling in_valid with new operands meanwhile -> z and out_valid stable, in_ready=0, no operand captured. Release -> IDLE in 1 cycle.
- Reset abort: assert rst_n=0 mid-BUSY (cycle 3) -> out_valid=0, z=0, in_ready=1 after release. The next op with chain=1, x=X, y=Y gives X·Y (acc cleared).
